// File: rtl/saw_avg_pkg.sv
// Shared types and constants for the saw_avg_filter moving-average stage.
package saw_avg_pkg;

    localparam int DATA_W       = 16;
    localparam int LOG2_MAX_WIN = 4;
    localparam int SUM_W        = DATA_W + LOG2_MAX_WIN;

    localparam logic [1:0] WIN_2  = 2'b00;
    localparam logic [1:0] WIN_4  = 2'b01;
    localparam logic [1:0] WIN_8  = 2'b10;
    localparam logic [1:0] WIN_16 = 2'b11;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL
    } fill_state_t;

    function automatic logic [2:0] win_log2(input logic [1:0] sel);
        case (sel)
            WIN_2:   return 3'd1;
            WIN_4:   return 3'd2;
            WIN_8:   return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/saw_avg_delay_line.sv
// Circular sample buffer: one write port at wr_ptr, combinational read at wr_ptr - rd_offset.
module saw_avg_delay_line #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_offset,
    output logic [DATA_W-1:0] rd_data
);

    // Contents are deliberately never cleared; the accumulator masks stale entries.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[wr_ptr - rd_offset];

endmodule

// File: rtl/saw_avg_filter.sv
// Moving-average smoother (window 2/4/8/16) behind the sawtooth generator.
// Define SAW_AVG_ROUND_EN for round-half-up output instead of truncation.
module saw_avg_filter #(
    parameter int DATA_W       = 16,
    parameter int LOG2_MAX_WIN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic [1:0]               win_sel,
    input  logic                     flush,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     settled
);
    import saw_avg_pkg::*;

    // state | meaning
    // EMPTY | no samples since last restart
    // FILL  | 0 < count < W, missing samples act as zeros
    // FULL  | window holds W real samples
    localparam int ACC_W = DATA_W + LOG2_MAX_WIN;
    localparam int CNT_W = LOG2_MAX_WIN + 1;

    fill_state_t             state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic [LOG2_MAX_WIN-1:0] wr_ptr_q;
    logic [1:0]              win_q, win_d;
    logic [2:0]              log2_w;
    logic [CNT_W-1:0]        win_len_q, win_len_d;
    logic                    restart;
    logic signed [DATA_W-1:0] x_old;
    logic signed [ACC_W-1:0] x_new_ext, x_old_ext;
    logic signed [ACC_W:0]   rnd_sum;
    logic signed [DATA_W-1:0] out_d;

    assign win_len_q = CNT_W'(1) << win_log2(win_q);

    saw_avg_delay_line #(
        .DATA_W (DATA_W),
        .ADDR_W (LOG2_MAX_WIN)
    ) u_delay_line (
        .clk       (clk),
        .wr_en     (in_valid && !rst),
        .wr_ptr    (wr_ptr_q),
        .wr_data   (in_sample),
        .rd_offset (win_len_q[LOG2_MAX_WIN-1:0]),
        .rd_data   (x_old)
    );

    always_comb begin
        restart   = flush || (win_sel != win_q);
        win_d     = win_q;
        sum_d     = sum_q;
        count_d   = count_q;
        x_new_ext = {{LOG2_MAX_WIN{in_sample[DATA_W-1]}}, in_sample};
        x_old_ext = (count_q < win_len_q) ? '0 : {{LOG2_MAX_WIN{x_old[DATA_W-1]}}, x_old};

        if (in_valid) begin
            if (restart) begin
                sum_d   = x_new_ext;
                count_d = CNT_W'(1);
                win_d   = win_sel;
            end else begin
                sum_d = sum_q + x_new_ext - x_old_ext;
                if (count_q != win_len_q) begin
                    count_d = count_q + 1'b1;
                end
            end
        end else if (flush) begin
            sum_d   = '0;
            count_d = '0;
        end

        log2_w    = win_log2(win_d);
        win_len_d = CNT_W'(1) << log2_w;
`ifdef SAW_AVG_ROUND_EN
        rnd_sum = {sum_d[ACC_W-1], sum_d} + ((ACC_W+1)'(1) << (log2_w - 3'd1));
`else
        rnd_sum = {sum_d[ACC_W-1], sum_d};
`endif
        out_d = DATA_W'(rnd_sum >>> log2_w);

        if (count_d == '0) begin
            state_d = EMPTY;
        end else if (count_d == win_len_d) begin
            state_d = FULL;
        end else begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            count_q    <= '0;
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            win_q      <= win_sel;
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            sum_q     <= sum_d;
            win_q     <= win_d;
            out_valid <= in_valid;
            if (in_valid) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                out_sample <= out_d;
            end
        end
    end

    assign settled = (state_q == FULL);

endmodule

// File: tb/tb_saw_avg_filter.sv
// Directed self-checking bench for saw_avg_filter (table vectors plus window-16 sequences).
module tb_saw_avg_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, in_valid, flush;
    logic signed [15:0] in_sample;
    logic [1:0]        win_sel;
    logic              out_valid, settled;
    logic signed [15:0] out_sample;

    int errors = 0;
    int checks = 0;

`ifdef SAW_AVG_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    saw_avg_filter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .win_sel    (win_sel),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .settled    (settled)
    );

    typedef struct {
        logic       r;
        logic [1:0] sel;
        logic       fl;
        logic       v;
        int         x;
        logic       ev;
        int         eo;
        logic       es;
    } vec_t;

    vec_t tbl [28];

    task automatic step(input logic r, input logic [1:0] s, input logic f,
                        input logic v, input int x);
        @(negedge clk);
        rst       = r;
        win_sel   = s;
        flush     = f;
        in_valid  = v;
        in_sample = 16'(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_sample = '0; win_sel = 2'b01;

        //          r  sel    fl v  x       ev eo                  es
        tbl[0]  = '{1, 2'b01, 0, 0, 0,      0, 0,                  0};
        tbl[1]  = '{0, 2'b01, 0, 1, 4000,   1, 1000,               0};
        tbl[2]  = '{0, 2'b01, 0, 1, 8000,   1, 3000,               0};
        tbl[3]  = '{0, 2'b01, 0, 1, 12000,  1, 6000,               0};
        tbl[4]  = '{0, 2'b01, 0, 1, 16000,  1, 10000,              1};
        tbl[5]  = '{0, 2'b01, 0, 1, 20000,  1, 14000,              1};
        tbl[6]  = '{0, 2'b01, 0, 0, 0,      0, 14000,              1};
        tbl[7]  = '{1, 2'b00, 0, 0, 0,      0, 0,                  0};
        tbl[8]  = '{0, 2'b00, 0, 1, 30720,  1, 15360,              0};
        tbl[9]  = '{0, 2'b00, 0, 1, -32768, 1, -1024,              1};
        tbl[10] = '{0, 2'b00, 1, 1, 400,    1, 200,                0};
        tbl[11] = '{0, 2'b00, 1, 0, 0,      0, 200,                0};
        tbl[12] = '{0, 2'b00, 0, 1, 600,    1, 300,                0};
        tbl[13] = '{0, 2'b00, 0, 0, 0,      0, 300,                0};
        tbl[14] = '{0, 2'b00, 0, 0, 0,      0, 300,                0};
        tbl[15] = '{0, 2'b00, 0, 0, 0,      0, 300,                0};
        tbl[16] = '{0, 2'b00, 0, 1, 1000,   1, 800,                1};
        tbl[17] = '{0, 2'b00, 0, 1, 200,    1, 600,                1};
        for (int i = 18; i < 23; i++) tbl[i] = '{0, 2'b00, 0, 0, 0, 0, 600, 1};
        tbl[23] = '{0, 2'b00, 0, 1, 1400,   1, 800,                1};
        tbl[24] = '{1, 2'b01, 1, 1, 1234,   0, 0,                  0};
        tbl[25] = '{0, 2'b01, 0, 1, 2,      1, RND ? 1 : 0,        0};
        tbl[26] = '{1, 2'b00, 0, 0, 0,      0, 0,                  0};
        tbl[27] = '{0, 2'b00, 0, 1, -1,     1, RND ? 0 : -1,       0};

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].r, tbl[i].sel, tbl[i].fl, tbl[i].v, tbl[i].x);
            check($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(tbl[i].ev));
            check($sformatf("vec%0d_out_sample", i), int'(out_sample), tbl[i].eo);
            check($sformatf("vec%0d_settled", i), int'(settled), int'(tbl[i].es));
        end

        // W=4 settle, then switch to W=16 and refill
        step(1, 2'b01, 0, 0, 0);
        repeat (4) step(0, 2'b01, 0, 1, 4000);
        check("w4_settled_out", int'(out_sample), 4000);
        check("w4_settled", int'(settled), 1);
        step(0, 2'b11, 0, 0, 0);
        check("sel_change_idle_valid", int'(out_valid), 0);
        check("sel_change_idle_settled", int'(settled), 1);
        step(0, 2'b11, 0, 1, 8000);
        check("w16_restart_out", int'(out_sample), 500);
        check("w16_restart_settled", int'(settled), 0);
        for (int i = 0; i < 14; i++) begin
            step(0, 2'b11, 0, 1, 32767);
            check($sformatf("w16_fill%0d_settled", i), int'(settled), 0);
        end
        step(0, 2'b11, 0, 1, 32767);
        check("w16_full_out", int'(out_sample), 31219);
        check("w16_full_settled", int'(settled), 1);
        step(0, 2'b11, 0, 1, 32767);
        check("w16_max_out", int'(out_sample), 32767);
        repeat (16) step(0, 2'b11, 0, 1, -32768);
        check("w16_min_out", int'(out_sample), -32768);
        check("w16_min_settled", int'(settled), 1);
        check("w16_min_valid", int'(out_valid), 1);
        step(0, 2'b11, 0, 0, 0);
        check("w16_idle_valid", int'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
